// File: rtl/bnn_spi_pkg.sv
// bnn_spi_pkg: command bytes, sequencer state type and default image size shared by the SPI/BNN blocks.
package bnn_spi_pkg;
   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_LOAD  = 8'h02;
   localparam logic [7:0] CMD_INFER = 8'h03;
   localparam int IMG_BYTES_DEF = 128;
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_INFER} state_e;
endpackage

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: decodes SPI command bytes, streams image bytes to the buffer, runs inference; SPI_CMD_CTRL_TIMEOUT_EN adds a LOAD inter-byte timeout.
module spi_cmd_ctrl import bnn_spi_pkg::*; #(
   parameter int IMG_BYTES = IMG_BYTES_DEF,
   parameter int ADDR_W = $clog2(IMG_BYTES),
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        spi_rx_data,
   input  logic              byte_valid,
   output logic              rx_enable,
   output logic              byte_taken,
   output logic              buf_we,
   output logic [ADDR_W-1:0] buf_addr,
   output logic [7:0]        buf_wdata,
   output logic              infer_start,
   input  logic              infer_done,
   input  logic [3:0]        infer_result,
   output logic [3:0]        result,
   output logic              result_valid,
   output logic              img_loaded,
   output logic              busy,
   output logic              err
);
   state_e state_q, state_d;
   logic [1:0] guard_q, guard_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d, buf_addr_q, buf_addr_d;
   logic [7:0] buf_wdata_q, buf_wdata_d;
   logic [3:0] result_q, result_d;
   logic rx_en_q, rx_en_d, taken_q, taken_d, buf_we_q, buf_we_d, infer_start_q, infer_start_d;
   logic result_valid_q, result_valid_d, img_loaded_q, img_loaded_d, err_q, err_d;
   logic accept, last;
`ifdef SPI_CMD_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_q, tmo_d;
`endif

   always_comb begin
      accept = byte_valid && guard_q == 2'd0 && state_q != S_WAIT_INFER;
      last = cnt_q == ADDR_W'(IMG_BYTES - 1);
      state_d = state_q;
      guard_d = accept ? 2'd2 : (guard_q != 2'd0 ? guard_q - 2'd1 : 2'd0);
      cnt_d = cnt_q;
      taken_d = accept;
      buf_we_d = 1'b0;
      buf_addr_d = buf_addr_q;
      buf_wdata_d = accept ? spi_rx_data : buf_wdata_q;
      infer_start_d = 1'b0;
      result_d = result_q;
      result_valid_d = result_valid_q;
      img_loaded_d = img_loaded_q;
      err_d = err_q;
`ifdef SPI_CMD_CTRL_TIMEOUT_EN
      tmo_d = (state_q == S_LOAD && !accept) ? tmo_q + TW'(1) : '0;
`endif
      case (state_q)
         S_IDLE: if (accept) begin
            if (spi_rx_data == CMD_CLEAR) begin
               img_loaded_d = 1'b0;
               result_valid_d = 1'b0;
               err_d = 1'b0;
            end else if (spi_rx_data == CMD_LOAD) begin
               img_loaded_d = 1'b0;
               result_valid_d = 1'b0;
               cnt_d = '0;
               state_d = S_LOAD;
            end else if (spi_rx_data == CMD_INFER && img_loaded_q) begin
               infer_start_d = 1'b1;
               result_valid_d = 1'b0;
               state_d = S_WAIT_INFER;
            end else begin
               err_d = 1'b1;
            end
         end
         S_LOAD: if (accept) begin
            buf_we_d = 1'b1;
            buf_addr_d = cnt_q;
            cnt_d = last ? cnt_q : cnt_q + ADDR_W'(1);
            img_loaded_d = last;
            state_d = last ? S_IDLE : S_LOAD;
         end
`ifdef SPI_CMD_CTRL_TIMEOUT_EN
         else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            err_d = 1'b1;
            state_d = S_IDLE;
         end
`endif
         S_WAIT_INFER: if (infer_done) begin
            result_d = infer_result;
            result_valid_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      rx_en_d = state_d != S_WAIT_INFER;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         guard_q <= '0;
         cnt_q <= '0;
         buf_addr_q <= '0;
         buf_wdata_q <= '0;
         result_q <= '0;
         rx_en_q <= 1'b0;
         taken_q <= 1'b0;
         buf_we_q <= 1'b0;
         infer_start_q <= 1'b0;
         result_valid_q <= 1'b0;
         img_loaded_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         guard_q <= guard_d;
         cnt_q <= cnt_d;
         buf_addr_q <= buf_addr_d;
         buf_wdata_q <= buf_wdata_d;
         result_q <= result_d;
         rx_en_q <= rx_en_d;
         taken_q <= taken_d;
         buf_we_q <= buf_we_d;
         infer_start_q <= infer_start_d;
         result_valid_q <= result_valid_d;
         img_loaded_q <= img_loaded_d;
         err_q <= err_d;
      end
   end

`ifdef SPI_CMD_CTRL_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tmo_q <= '0;
      else tmo_q <= tmo_d;
   end
`endif

   assign rx_enable = rx_en_q;
   assign byte_taken = taken_q;
   assign buf_we = buf_we_q;
   assign buf_addr = buf_addr_q;
   assign buf_wdata = buf_wdata_q;
   assign infer_start = infer_start_q;
   assign result = result_q;
   assign result_valid = result_valid_q;
   assign img_loaded = img_loaded_q;
   assign busy = state_q != S_IDLE;
   assign err = err_q;
endmodule
